// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs the interval timer, services its interrupts
// and reads back the 64-bit counter snapshot on every tick.
//
// state      | meaning
// IDLE       | timer not owned, waiting for start
// WR_PER     | writing period halfwords to addresses 2..5
// WR_CTRL    | writing control = ITO|CONT|START
// WAIT_IRQ   | bus idle, waiting for irq or pending stop
// CLR_STAT   | clearing interrupt status
// WR_SNAP    | latching the counter snapshot
// RD_SNAP    | reading snapshot halfwords from addresses 6..9
// RD_LAST    | capturing the last halfword, publishing the snapshot
// WR_STOP    | writing control = STOP
module timer_ctrl_master #(
   parameter int TICK_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [63:0]       period,
   input  logic              irq,
   output logic [3:0]        address,
   output logic              chipselect,
   output logic              write_n,
   output logic [15:0]       writedata,
   input  logic [15:0]       readdata,
   output logic              busy,
   output logic              running,
   output logic [TICK_W-1:0] tick_count,
   output logic [63:0]       snap_value,
   output logic              snap_valid
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_PER, S_WR_CTRL, S_WAIT_IRQ, S_CLR_STAT,
      S_WR_SNAP, S_RD_SNAP, S_RD_LAST, S_WR_STOP
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_beat, w_beat_nxt;
   logic [63:0]       r_period, w_per_src;
   logic [47:0]       r_shadow;
   logic [63:0]       r_snap;
   logic              r_cs, r_wn, w_cs_nxt, w_wn_nxt;
   logic [3:0]        r_addr, w_addr_nxt;
   logic [15:0]       r_wdata, w_wdata_nxt;
   logic              r_stop_pend, r_running, r_snap_vld, r_cap_vld;
   logic [1:0]        r_cap_idx;
   logic [TICK_W-1:0] r_ticks;

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      case (r_state)
         S_IDLE: if (start) begin
            w_state_nxt = S_WR_PER;
            w_beat_nxt  = 2'd0;
         end
         S_WR_PER: if (r_beat == 2'd3) begin
            w_state_nxt = S_WR_CTRL;
            w_beat_nxt  = 2'd0;
         end else begin
            w_beat_nxt = r_beat + 2'd1;
         end
         S_WR_CTRL:  w_state_nxt = S_WAIT_IRQ;
         S_WAIT_IRQ: if (r_stop_pend)  w_state_nxt = S_WR_STOP;
                     else if (irq)     w_state_nxt = S_CLR_STAT;
         S_CLR_STAT: w_state_nxt = S_WR_SNAP;
         S_WR_SNAP: begin
            w_state_nxt = S_RD_SNAP;
            w_beat_nxt  = 2'd0;
         end
         S_RD_SNAP: if (r_beat == 2'd3) begin
            w_state_nxt = S_RD_LAST;
            w_beat_nxt  = 2'd0;
         end else begin
            w_beat_nxt = r_beat + 2'd1;
         end
         S_RD_LAST:  w_state_nxt = S_WAIT_IRQ;
         S_WR_STOP:  w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Bus outputs are decoded from the next state so they are registered
   // and line up with the cycle the FSM spends in that state.
   always_comb begin
      w_per_src   = (r_state == S_IDLE) ? period : r_period;
      w_cs_nxt    = 1'b0;
      w_wn_nxt    = 1'b1;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      case (w_state_nxt)
         S_WR_PER: begin
            w_cs_nxt    = 1'b1;
            w_wn_nxt    = 1'b0;
            w_addr_nxt  = 4'd2 + {2'b00, w_beat_nxt};
            w_wdata_nxt = w_per_src[{w_beat_nxt, 4'b0000} +: 16];
         end
         S_WR_CTRL: begin
            w_cs_nxt    = 1'b1;
            w_wn_nxt    = 1'b0;
            w_addr_nxt  = 4'd1;
            w_wdata_nxt = 16'h0007;
         end
         S_CLR_STAT: begin
            w_cs_nxt    = 1'b1;
            w_wn_nxt    = 1'b0;
            w_addr_nxt  = 4'd0;
            w_wdata_nxt = 16'h0000;
         end
         S_WR_SNAP: begin
            w_cs_nxt    = 1'b1;
            w_wn_nxt    = 1'b0;
            w_addr_nxt  = 4'd6;
            w_wdata_nxt = 16'h0000;
         end
         S_RD_SNAP: begin
            w_cs_nxt   = 1'b1;
            w_addr_nxt = 4'd6 + {2'b00, w_beat_nxt};
         end
         S_WR_STOP: begin
            w_cs_nxt    = 1'b1;
            w_wn_nxt    = 1'b0;
            w_addr_nxt  = 4'd1;
            w_wdata_nxt = 16'h0008;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_beat      <= 2'd0;
         r_period    <= '0;
         r_shadow    <= '0;
         r_snap      <= '0;
         r_cs        <= 1'b0;
         r_wn        <= 1'b1;
         r_addr      <= 4'd0;
         r_wdata     <= 16'h0000;
         r_stop_pend <= 1'b0;
         r_running   <= 1'b0;
         r_snap_vld  <= 1'b0;
         r_cap_vld   <= 1'b0;
         r_cap_idx   <= 2'd0;
         r_ticks     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         r_cs    <= w_cs_nxt;
         r_wn    <= w_wn_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;

         if (r_state == S_IDLE && start) begin
            r_period <= period;
            r_ticks  <= '0;
         end

         // A stop seen in IDLE (including alongside start) is dropped.
         if (r_state == S_IDLE || (r_state == S_WAIT_IRQ && r_stop_pend))
            r_stop_pend <= 1'b0;
         else if (stop)
            r_stop_pend <= 1'b1;

         if (r_state == S_WR_CTRL)
            r_running <= 1'b1;
         else if (r_state == S_WR_STOP)
            r_running <= 1'b0;

         // Read data arrives one cycle after the read beat; addresses 6..9
         // map to halfword 0..3 via the low two address bits plus two.
         r_cap_vld <= r_cs & r_wn;
         r_cap_idx <= r_addr[1:0] + 2'd2;
         if (r_cap_vld) begin
            case (r_cap_idx)
               2'd0:    r_shadow[15:0]  <= readdata;
               2'd1:    r_shadow[31:16] <= readdata;
               2'd2:    r_shadow[47:32] <= readdata;
               default: ;
            endcase
         end

         r_snap_vld <= (r_state == S_RD_LAST);
         if (r_state == S_RD_LAST) begin
            r_snap  <= {readdata, r_shadow};
            r_ticks <= r_ticks + TICK_W'(1);
         end
      end
   end

   assign address    = r_addr;
   assign chipselect = r_cs;
   assign write_n    = r_wn;
   assign writedata  = r_wdata;
   assign busy       = (r_state != S_IDLE);
   assign running    = r_running;
   assign tick_count = r_ticks;
   assign snap_value = r_snap;
   assign snap_valid = r_snap_vld;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Directed bench for timer_ctrl_master: bus transactions are checked against
// a scoreboard queue, snapshot/tick/status outputs against bench constants.
module tb_timer_ctrl_master;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, stop, irq;
   logic [63:0] period;
   logic [15:0] readdata;
   logic [3:0]  address;
   logic        chipselect, write_n, busy, running, snap_valid;
   logic [15:0] writedata;
   logic [31:0] tick_count;
   logic [63:0] snap_value;

   logic        reset4, start4, stop4, irq4;
   logic [63:0] period4;
   logic [15:0] readdata4;
   logic [3:0]  address4;
   logic        chipselect4, write_n4, busy4, running4, snap_valid4;
   logic [15:0] writedata4;
   logic [3:0]  tick_count4;
   logic [63:0] snap_value4;

   timer_ctrl_master #(.TICK_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .period(period),
      .irq(irq), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(readdata), .busy(busy), .running(running),
      .tick_count(tick_count), .snap_value(snap_value), .snap_valid(snap_valid));

   timer_ctrl_master #(.TICK_W(4)) dut4 (
      .clk(clk), .reset(reset4), .start(start4), .stop(stop4), .period(period4),
      .irq(irq4), .address(address4), .chipselect(chipselect4), .write_n(write_n4),
      .writedata(writedata4), .readdata(readdata4), .busy(busy4), .running(running4),
      .tick_count(tick_count4), .snap_value(snap_value4), .snap_valid(snap_valid4));

   int          n_cmp = 0;
   int          n_err = 0;
   logic [20:0] exp_q[$];
   logic [63:0] snap_model;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [20:0] wr(input logic [3:0] a, input logic [15:0] d);
      return {1'b0, a, d};
   endfunction

   function automatic logic [20:0] rd(input logic [3:0] a);
      return {1'b1, a, 16'h0000};
   endfunction

   task automatic push_service();
      exp_q.push_back(wr(4'd0, 16'h0000));
      exp_q.push_back(wr(4'd6, 16'h0000));
      for (int i = 6; i <= 9; i++) exp_q.push_back(rd(4'(i)));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_snap(output int n);
      n = 0;
      while (n < 20) begin
         tick(1);
         n++;
         if (snap_valid === 1'b1) break;
      end
   endtask

   // Timer slave read port, fixed latency 1.
   always @(posedge clk) begin
      if (chipselect === 1'b1 && write_n === 1'b1) begin
         case (address)
            4'd6:    readdata <= snap_model[15:0];
            4'd7:    readdata <= snap_model[31:16];
            4'd8:    readdata <= snap_model[47:32];
            4'd9:    readdata <= snap_model[63:48];
            default: readdata <= 16'h0000;
         endcase
      end
   end

   // Bus monitor: every cycle with chipselect must match the scoreboard head.
   always @(negedge clk) begin
      logic [20:0] got;
      if (chipselect === 1'b1) begin
         got = {write_n, address, (write_n ? 16'h0000 : writedata)};
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL bus_unexpected: observed %h expected none", got);
         end
         if (exp_q.size() != 0) check("bus_txn", {43'd0, got}, {43'd0, exp_q.pop_front()});
      end
   end

   initial begin
      int n;
      int cnt;
      reset = 1'b1; start = 1'b0; stop = 1'b0; irq = 1'b0; period = '0;
      readdata = 16'h0; snap_model = '0;
      reset4 = 1'b1; start4 = 1'b0; stop4 = 1'b0; irq4 = 1'b0; period4 = '0;
      readdata4 = 16'h0;

      tick(3);
      check("rst_chipselect", chipselect, 1'b0);
      check("rst_write_n", write_n, 1'b1);
      check("rst_address", address, 4'd0);
      check("rst_writedata", writedata, 16'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_running", running, 1'b0);
      check("rst_tick", tick_count, 32'd0);
      check("rst_snap_value", snap_value, 64'd0);
      check("rst_snap_valid", snap_valid, 1'b0);
      reset = 1'b0; reset4 = 1'b0;
      tick(2);

      // Program; stop in the same IDLE cycle as start must be discarded.
      period = 64'h0000_0001_0000_C34F;
      exp_q.push_back(wr(4'd2, 16'hC34F));
      exp_q.push_back(wr(4'd3, 16'h0000));
      exp_q.push_back(wr(4'd4, 16'h0001));
      exp_q.push_back(wr(4'd5, 16'h0000));
      exp_q.push_back(wr(4'd1, 16'h0007));
      start = 1'b1; stop = 1'b1;
      tick(1);
      start = 1'b0; stop = 1'b0; period = '0;
      check("prog_busy", busy, 1'b1);
      tick(4);
      check("prog_running_early", running, 1'b0);
      tick(1);
      check("prog_running", running, 1'b1);
      check("prog_q_empty", exp_q.size(), 0);
      tick(6);
      check("start_stop_busy", busy, 1'b1);

      // Single service.
      snap_model = 64'h0123_4567_89AB_CDEF;
      push_service();
      irq = 1'b1;
      tick(1);
      irq = 1'b0;
      wait_snap(n);
      check("svc_latency", n + 1, 8);
      check("svc_snap", snap_value, 64'h0123_4567_89AB_CDEF);
      check("svc_tick", tick_count, 32'd1);
      check("svc_q_empty", exp_q.size(), 0);
      tick(1);
      check("svc_pulse_width", snap_valid, 1'b0);
      tick(3);

      // Back-to-back with irq held high.
      snap_model = 64'hFEDC_BA98_7654_3210;
      for (int k = 0; k < 3; k++) push_service();
      irq = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_snap(n);
         check("b2b_interval", n, 8);
      end
      irq = 1'b0;
      check("b2b_tick", tick_count, 32'd4);
      check("b2b_snap", snap_value, 64'hFEDC_BA98_7654_3210);
      check("b2b_q_empty", exp_q.size(), 0);
      tick(4);

      // Stop at RD_SNAP beat 2.
      snap_model = 64'h1111_2222_3333_4444;
      push_service();
      exp_q.push_back(wr(4'd1, 16'h0008));
      irq = 1'b1;
      tick(1);
      irq = 1'b0;
      tick(4);
      check("stop_beat2_addr", address, 4'd8);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      wait_snap(n);
      check("stop_snap_latency", n, 2);
      check("stop_snap", snap_value, 64'h1111_2222_3333_4444);
      check("stop_tick", tick_count, 32'd5);
      tick(1);
      check("stop_wr_busy", busy, 1'b1);
      tick(1);
      check("stop_busy", busy, 1'b0);
      check("stop_running", running, 1'b0);
      check("stop_q_empty", exp_q.size(), 0);

      // Stop in IDLE is ignored; start while busy is ignored.
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      tick(5);
      check("idle_stop_busy", busy, 1'b0);
      check("idle_stop_tick", tick_count, 32'd5);
      period = 64'hAAAA_BBBB_CCCC_DDDD;
      exp_q.push_back(wr(4'd2, 16'hDDDD));
      exp_q.push_back(wr(4'd3, 16'hCCCC));
      exp_q.push_back(wr(4'd4, 16'hBBBB));
      exp_q.push_back(wr(4'd5, 16'hAAAA));
      exp_q.push_back(wr(4'd1, 16'h0007));
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
      period = 64'h0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(10);
      check("busy_start_q_empty", exp_q.size(), 0);
      check("busy_start_running", running, 1'b1);
      check("busy_start_tick", tick_count, 32'd0);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(4);
      check("wait_start_busy", busy, 1'b1);
      check("wait_start_tick", tick_count, 32'd0);

      // Reset during RD_SNAP beat 1.
      push_service();
      irq = 1'b1;
      tick(1);
      irq = 1'b0;
      tick(3);
      check("mid_rd_addr", address, 4'd7);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mid_rst_q_left", exp_q.size(), 2);
      exp_q.delete();
      check("mid_rst_chipselect", chipselect, 1'b0);
      check("mid_rst_write_n", write_n, 1'b1);
      check("mid_rst_address", address, 4'd0);
      check("mid_rst_writedata", writedata, 16'h0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_running", running, 1'b0);
      check("mid_rst_snap", snap_value, 64'd0);
      check("mid_rst_snap_valid", snap_valid, 1'b0);
      tick(5);
      check("mid_rst_idle", busy, 1'b0);

      // Tick counter wrap with TICK_W = 4.
      period4 = 64'd5;
      start4 = 1'b1;
      tick(1);
      start4 = 1'b0;
      tick(6);
      irq4 = 1'b1;
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         tick(1);
         if (snap_valid4 === 1'b1) cnt++;
         if (cnt == 17) break;
      end
      irq4 = 1'b0;
      check("wrap_services", cnt, 17);
      check("wrap_tick", tick_count4, 4'd1);
      tick(12);
      check("wrap_tick_hold", tick_count4, 4'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
